// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/subtract with the carry chain split into
// STAGES registered chunks, behind a single-enable valid/ready pipeline.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int CHUNK = WIDTH / STAGES;

    logic en;

    // stage k inputs: operands, partial sum and carry entering stage k
    logic             v_d [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic             c_d [STAGES];

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign v_d[0] = in_valid;
    assign a_d[0] = in1;
    assign b_d[0] = sub ? ~in2 : in2;
    assign c_d[0] = sub ^ cin;
    assign s_d[0] = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK:0]   csum;
        logic [WIDTH-1:0] s_n;

        assign csum = {1'b0, a_d[k][k*CHUNK +: CHUNK]}
                    + {1'b0, b_d[k][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, c_d[k]};

        always_comb begin
            s_n = s_d[k];
            s_n[k*CHUNK +: CHUNK] = csum[CHUNK-1:0];
        end

        if (k < STAGES - 1) begin : g_mid
            logic             v_q;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] s_q;
            logic             c_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v_q <= 1'b0;
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                end else if (en) begin
                    v_q <= v_d[k];
                    if (v_d[k]) begin
                        a_q <= a_d[k];
                        b_q <= b_d[k];
                        s_q <= s_n;
                        c_q <= csum[CHUNK];
                    end
                end
            end

            assign v_d[k+1] = v_q;
            assign a_d[k+1] = a_q;
            assign b_d[k+1] = b_q;
            assign s_d[k+1] = s_q;
            assign c_d[k+1] = c_q;
        end else begin : g_last
            // lower chunks of the operands were consumed by earlier stages
            logic unused_ops;
            assign unused_ops = ^{a_d[k], b_d[k]};

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    out_valid <= 1'b0;
                    out       <= '0;
                    cout      <= 1'b0;
                    ovf       <= 1'b0;
                    zero      <= 1'b0;
                end else if (en) begin
                    out_valid <= v_d[k];
                    if (v_d[k]) begin
                        out  <= s_n;
                        cout <= csum[CHUNK];
                        ovf  <= (a_d[k][WIDTH-1] == b_d[k][WIDTH-1])
                             && (s_n[WIDTH-1] != a_d[k][WIDTH-1]);
                        zero <= ~|s_n;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: table, directed and random checks of pipelined_addsub
// at STAGES = 1, 2, 4 (WIDTH = 32) against an arithmetic reference model.
module tb_pipelined_addsub;
    localparam int N = 3;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        c;
        logic [31:0] o;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    typedef struct {
        logic [31:0] o;
        logic        co;
        logic        ov;
        logic        z;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        iv   [N];
    logic        ordy [N];
    logic        irdy [N];
    logic        ovld [N];
    logic [31:0] res  [N];
    logic        co   [N];
    logic        of   [N];
    logic        zf   [N];
    logic [31:0] in1;
    logic [31:0] in2;
    logic        sub;
    logic        cin;

    int   nvec = 0;
    int   nerr = 0;
    res_t q [N][$];
    vec_t tbl [10];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        pipelined_addsub #(
            .WIDTH (32),
            .STAGES(g == 0 ? 1 : (g == 1 ? 2 : 4))
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .in_valid (iv[g]),
            .in_ready (irdy[g]),
            .in1      (in1),
            .in2      (in2),
            .sub      (sub),
            .cin      (cin),
            .out_valid(ovld[g]),
            .out_ready(ordy[g]),
            .out      (res[g]),
            .cout     (co[g]),
            .ovf      (of[g]),
            .zero     (zf[g])
        );
    end

    function automatic int lat(int i);
        return i == 0 ? 1 : (i == 1 ? 2 : 4);
    endfunction

    // integer arithmetic view of the operation, independent of any carry chain
    function automatic res_t model(logic [31:0] a, logic [31:0] b,
                                   logic s, logic c);
        longint ua = longint'({32'h0, a});
        longint ub = longint'({32'h0, b});
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ci = longint'({63'h0, c});
        longint ur;
        longint sr;
        res_t   r;
        if (s) begin
            ur   = ua - ub - ci;
            sr   = sa - sb - ci;
            r.co = ua >= ub + ci;
        end else begin
            ur   = ua + ub + ci;
            sr   = sa + sb + ci;
            r.co = ur >= 64'sd4294967296;
        end
        r.o  = ur[31:0];
        r.ov = sr > 64'sd2147483647 || sr < -64'sd2147483648;
        r.z  = r.o == 32'h0;
        return r;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic chk(string name, int i, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s [STAGES=%0d]: got %h, want %h",
                     name, lat(i), act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(logic [31:0] a, logic [31:0] b, logic s, logic c);
        in1 = a;
        in2 = b;
        sub = s;
        cin = c;
    endtask

    task automatic set_all(logic v, logic r);
        for (int i = 0; i < N; i++) begin
            iv[i]   = v;
            ordy[i] = r;
        end
    endtask

    // scoreboard: runs every falling edge, between the driving and active edges
    task automatic monitor();
        res_t e;
        if (reset) begin
            for (int i = 0; i < N; i++) q[i].delete();
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (ovld[i]) begin
                if (q[i].size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL spurious [STAGES=%0d]: got %h, want none",
                             lat(i), res[i]);
                end else begin
                    e = q[i][0];
                    chk("model", i, 64'({res[i], co[i], of[i], zf[i]}),
                        64'({e.o, e.co, e.ov, e.z}));
                    if (ordy[i]) void'(q[i].pop_front());
                    else chk("stall in_ready", i, 64'(irdy[i]), 64'(0));
                end
            end
            if (iv[i] && irdy[i]) q[i].push_back(model(in1, in2, sub, cin));
        end
    endtask

    task automatic run_vec(vec_t v);
        bit seen [N];
        set_op(v.a, v.b, v.s, v.c);
        set_all(1'b1, 1'b1);
        step();
        for (int i = 0; i < N; i++) iv[i] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!seen[i] && ovld[i]) begin
                    seen[i] = 1'b1;
                    chk("latency", i, 64'(c), 64'(lat(i)));
                    chk("vector", i, 64'({res[i], co[i], of[i], zf[i]}),
                        64'({v.o, v.co, v.ov, v.z}));
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!seen[i]) begin
                nvec++;
                nerr++;
                $display("FAIL timeout [STAGES=%0d]: got no result, want %h",
                         lat(i), v.o);
            end
        end
        step();
    endtask

    initial begin
        logic [31:0] got [$];
        int          idx;
        int          stall;
        bit          seen;
        int          first [N];
        int          last  [N];
        int          cnt   [N];

        tbl[0] = '{32'h0000_FFFF, 32'h0000_0001, 0, 0, 32'h0001_0000, 0, 0, 0};
        tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1, 0};
        tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 32'h0000_0000, 1, 0, 1};
        tbl[3] = '{32'h0000_0005, 32'h0000_0007, 1, 0, 32'hFFFF_FFFE, 0, 0, 0};
        tbl[4] = '{32'h0000_0007, 32'h0000_0007, 1, 1, 32'hFFFF_FFFF, 0, 0, 0};
        tbl[5] = '{32'h8000_0000, 32'h0000_0001, 1, 0, 32'h7FFF_FFFF, 1, 1, 0};
        tbl[6] = '{32'h0000_0001, 32'h0000_0002, 0, 1, 32'h0000_0004, 0, 0, 0};
        tbl[7] = '{32'h0000_0007, 32'h0000_0007, 1, 0, 32'h0000_0000, 1, 0, 1};
        tbl[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFF, 1, 0, 0};
        tbl[9] = '{32'h0000_0000, 32'h0000_0000, 1, 1, 32'hFFFF_FFFF, 0, 0, 0};

        set_all(1'b0, 1'b1);
        set_op(32'h0, 32'h0, 1'b0, 1'b0);
        fork
            forever begin
                @(negedge clk);
                monitor();
            end
        join_none

        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            chk("reset out_valid", i, 64'(ovld[i]), 64'(0));
            chk("reset outputs", i, 64'({res[i], co[i], of[i], zf[i]}), 64'(0));
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < N; i++) chk("in_ready after reset", i, 64'(irdy[i]), 64'(1));

        for (int t = 0; t < 10; t++) run_vec(tbl[t]);

        // reset while two operations are in flight
        set_all(1'b1, 1'b1);
        set_op($urandom | 32'h1, $urandom, 1'b0, 1'b1);
        step();
        set_op($urandom | 32'h1, $urandom, 1'b0, 1'b1);
        step();
        for (int i = 0; i < N; i++) iv[i] = 1'b0;
        chk("pre-reset out_valid", 0, 64'(ovld[0]), 64'(1));
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            chk("mid reset out_valid", i, 64'(ovld[i]), 64'(0));
            chk("mid reset out", i, 64'(res[i]), 64'(0));
        end
        step();
        reset = 1'b0;
        run_vec('{32'd10, 32'd20, 1'b0, 1'b0, 32'd30, 1'b0, 1'b0, 1'b0});

        // back-pressure on the two-stage instance
        set_all(1'b0, 1'b1);
        idx   = 0;
        stall = 0;
        seen  = 1'b0;
        for (int cyc = 0; cyc < 30 && got.size() < 4; cyc++) begin
            if (ovld[1] && !seen) begin
                seen  = 1'b1;
                stall = 3;
            end
            ordy[1] = stall == 0;
            iv[1]   = idx < 4;
            set_op(32'(idx + 1), 32'(idx + 1), 1'b0, 1'b0);
            #1;
            if (stall > 0) begin
                chk("bp in_ready", 1, 64'(irdy[1]), 64'(0));
                chk("bp held out", 1, 64'(res[1]), 64'(2));
            end
            if (iv[1] && irdy[1]) idx++;
            if (ovld[1] && ordy[1]) got.push_back(res[1]);
            if (stall > 0) stall--;
            step();
        end
        iv[1]   = 1'b0;
        ordy[1] = 1'b1;
        chk("bp count", 1, 64'(got.size()), 64'(4));
        for (int j = 0; j < got.size(); j++)
            chk("bp order", 1, 64'(got[j]), 64'(2 * (j + 1)));
        repeat (6) step();

        // throughput: 16 back-to-back operations
        for (int i = 0; i < N; i++) begin
            first[i] = -1;
            last[i]  = -1;
            cnt[i]   = 0;
        end
        for (int c = 0; c < 24; c++) begin
            set_all(c < 16, 1'b1);
            set_op(pick(), pick(), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
            step();
            for (int i = 0; i < N; i++) begin
                if (ovld[i]) begin
                    if (first[i] < 0) first[i] = c;
                    last[i] = c;
                    cnt[i]++;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            chk("stream first", i, 64'(first[i]), 64'(lat(i) - 1));
            chk("stream count", i, 64'(cnt[i]), 64'(16));
            chk("stream span", i, 64'(last[i] - first[i]), 64'(15));
        end

        // random valid/ready traffic
        repeat (300) begin
            for (int i = 0; i < N; i++) begin
                iv[i]   = $urandom_range(0, 3) != 0;
                ordy[i] = $urandom_range(0, 3) != 0;
            end
            set_op(pick(), pick(), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
            step();
        end
        set_all(1'b0, 1'b1);
        repeat (8) step();
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) chk("drained", i, 64'(q[i].size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
